// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing a bank of storage registers between requesters A and B.
// Latency: Req at edge N -> Grant in cycle N+1, Done in cycle N+2; back-to-back spacing is 3 cycles.
module reg_bank_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 3,
   parameter int NUM_REGS = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              A_Req,
   input  logic              A_Write,
   input  logic [ADDR_W-1:0] A_Addr,
   input  logic [DATA_W-1:0] A_WData,
   output logic              A_Grant,
   output logic              A_Done,
   output logic [DATA_W-1:0] A_RData,
   input  logic              B_Req,
   input  logic              B_Write,
   input  logic [ADDR_W-1:0] B_Addr,
   input  logic [DATA_W-1:0] B_WData,
   output logic              B_Grant,
   output logic              B_Done,
   output logic [DATA_W-1:0] B_RData,
   output logic              Busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;   // 0 = A, 1 = B
   logic              prio_q, prio_d;     // requester that wins a tie
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] rd_val;
   logic              sel;

   // Addresses with no matching register fall through to zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_q == ADDR_W'(i)) rd_val = regs_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      prio_d    = prio_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      sel       = (A_Req && B_Req) ? prio_q : B_Req;
      case (state_q)
         S_IDLE: begin
            if (A_Req || B_Req) begin
               owner_d = sel;
               write_d = sel ? B_Write : A_Write;
               addr_d  = sel ? B_Addr  : A_Addr;
               wdata_d = sel ? B_WData : A_WData;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            prio_d  = ~owner_q;
            state_d = S_RESP;
            if (!write_q) begin
               if (owner_q) b_rdata_d = rd_val;
               else         a_rdata_d = rd_val;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         prio_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         prio_q    <= prio_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // Reset wins over a write sitting in ACCESS, so an aborted write never commits.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (state_q == S_ACCESS && write_q) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) regs_q[i] <= wdata_q;
         end
      end
   end

   assign A_Grant = (state_q == S_ACCESS) && !owner_q;
   assign B_Grant = (state_q == S_ACCESS) &&  owner_q;
   assign A_Done  = (state_q == S_RESP)   && !owner_q;
   assign B_Done  = (state_q == S_RESP)   &&  owner_q;
   assign Busy    = (state_q != S_IDLE);
   assign A_RData = a_rdata_q;
   assign B_RData = b_rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_reg_bank_arbiter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        A_Req = 1'b0, A_Write = 1'b0, B_Req = 1'b0, B_Write = 1'b0;
   logic [2:0]  A_Addr = '0, B_Addr = '0;
   logic [63:0] A_WData = '0, B_WData = '0;
   logic        A_Grant, A_Done, B_Grant, B_Done, Busy;
   logic [63:0] A_RData, B_RData;

   int checks = 0;
   int failures = 0;

   // Transaction-level model: register contents, last read results, tie-break owner.
   logic [63:0] mem [8];
   logic [63:0] exp_ard, exp_brd;
   bit          prio;

   reg_bank_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_WData(A_WData),
      .A_Grant(A_Grant), .A_Done(A_Done), .A_RData(A_RData),
      .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
      .B_Grant(B_Grant), .B_Done(B_Done), .B_RData(B_RData),
      .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   task automatic do_reset();
      Reset = 1'b1; A_Req = 1'b0; B_Req = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      exp_ard = '0; exp_brd = '0; prio = 1'b0;
   endtask

   task automatic set_req(input bit who, input bit wr, input logic [2:0] addr, input logic [63:0] data);
      if (!who) begin A_Req = 1'b1; A_Write = wr; A_Addr = addr; A_WData = data; end
      else      begin B_Req = 1'b1; B_Write = wr; B_Addr = addr; B_WData = data; end
   endtask

   // Issues one transaction from an idle bus and records when Grant and Done were seen.
   task automatic run_txn(input bit who, input bit wr, input logic [2:0] addr, input logic [63:0] data,
                          output logic [63:0] rd, output int gc, output int dc);
      @(negedge Clk);
      set_req(who, wr, addr, data);
      gc = -1; dc = -1; rd = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         if ((who ? B_Grant : A_Grant) && gc < 0) gc = c;
         if (who ? B_Done : A_Done) begin
            dc = c; rd = who ? B_RData : A_RData;
            break;
         end
      end
      if (!who) A_Req = 1'b0; else B_Req = 1'b0;
      if (wr) mem[addr] = data;
      else if (who) exp_brd = mem[addr];
      else exp_ard = mem[addr];
      prio = ~who;
   endtask

   task automatic test_reset();
      logic [63:0] rd; int gc, dc;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         checks++;
         if ({Busy, A_Grant, B_Grant, A_Done, B_Done} !== 5'b0 || A_RData !== 64'h0 || B_RData !== 64'h0) begin
            failures++;
            $display("FAIL reset_idle c=%0d got busy/g/d=%b ard=%h brd=%h expected all zero", c,
                     {Busy, A_Grant, B_Grant, A_Done, B_Done}, A_RData, B_RData);
         end
      end
      run_txn(1'b0, 1'b0, 3'd6, 64'h0, rd, gc, dc);
      checks++;
      if (rd !== 64'h0 || dc !== 2) begin
         failures++;
         $display("FAIL reset_read rd=%h done_cyc=%0d expected 0 and 2", rd, dc);
      end
   endtask

   task automatic test_write_read();
      logic [63:0] rd; int gc, dc;
      run_txn(1'b0, 1'b1, 3'd3, 64'hDEAD_BEEF_0123_4567, rd, gc, dc);
      checks++;
      if (gc !== 1 || dc !== 2) begin
         failures++;
         $display("FAIL write_latency grant_cyc=%0d done_cyc=%0d expected 1 and 2", gc, dc);
      end
      run_txn(1'b0, 1'b0, 3'd3, 64'h0, rd, gc, dc);
      checks++;
      if (rd !== 64'hDEAD_BEEF_0123_4567 || gc !== 1 || dc !== 2) begin
         failures++;
         $display("FAIL read_back rd=%h g=%0d d=%0d expected DEADBEEF01234567 1 2", rd, gc, dc);
      end
      checks++;
      if (B_RData !== exp_brd) begin
         failures++;
         $display("FAIL other_rdata got=%h expected=%h", B_RData, exp_brd);
      end
   endtask

   task automatic test_contention();
      int ord [6]; int cyc [6]; logic [63:0] ard [3];
      int n = 0; int na = 0;
      do_reset();
      @(negedge Clk);
      set_req(1'b0, 1'b0, 3'd5, 64'h0);
      set_req(1'b1, 1'b1, 3'd5, 64'h1);
      for (int c = 1; c <= 40 && n < 6; c++) begin
         @(negedge Clk);
         if (A_Done && n < 6) begin
            ord[n] = 0; cyc[n] = c; n++;
            if (na < 3) begin ard[na] = A_RData; na++; end
         end
         if (B_Done && n < 6) begin ord[n] = 1; cyc[n] = c; n++; end
      end
      A_Req = 1'b0; B_Req = 1'b0;
      mem[5] = 64'h1; exp_ard = 64'h1; prio = 1'b0;
      checks++;
      if (n !== 6) begin failures++; $display("FAIL contention_count got=%0d expected 6", n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (ord[i] !== (i % 2)) begin
            failures++; $display("FAIL contention_order i=%0d got=%0d expected=%0d", i, ord[i], i % 2);
         end
         if (i > 0) begin
            checks++;
            if (cyc[i] - cyc[i-1] !== 3) begin
               failures++; $display("FAIL contention_spacing i=%0d got=%0d expected 3", i, cyc[i] - cyc[i-1]);
            end
         end
      end
      if (na >= 2) begin
         checks++;
         if (ard[0] !== 64'h0 || ard[1] !== 64'h1) begin
            failures++; $display("FAIL contention_rdata got=%h,%h expected 0,1", ard[0], ard[1]);
         end
      end
   endtask

   task automatic test_cross_visibility();
      int order = 0; int a_at = -1; int b_at = -1; logic [63:0] brd = '0;
      do_reset();
      @(negedge Clk);
      set_req(1'b0, 1'b1, 3'd7, 64'hFFFF_0000_FFFF_0000);
      set_req(1'b1, 1'b0, 3'd7, 64'h0);
      for (int c = 1; c <= 20 && b_at < 0; c++) begin
         @(negedge Clk);
         if (A_Done) begin a_at = order; order++; A_Req = 1'b0; end
         if (B_Done) begin b_at = order; order++; brd = B_RData; B_Req = 1'b0; end
      end
      A_Req = 1'b0; B_Req = 1'b0;
      mem[7] = 64'hFFFF_0000_FFFF_0000; exp_brd = mem[7]; prio = 1'b0;
      checks++;
      if (a_at !== 0 || b_at !== 1 || brd !== 64'hFFFF_0000_FFFF_0000) begin
         failures++;
         $display("FAIL cross_visibility a_pos=%0d b_pos=%0d brd=%h expected 0 1 FFFF0000FFFF0000", a_at, b_at, brd);
      end
   endtask

   task automatic test_field_change();
      logic [63:0] rd; int gc, dc; logic [63:0] exp2;
      @(negedge Clk);
      set_req(1'b0, 1'b1, 3'd1, 64'hAA);
      @(negedge Clk);
      checks++;
      if (A_Grant !== 1'b1) begin failures++; $display("FAIL field_grant got=%b expected 1", A_Grant); end
      A_Addr = 3'd2; A_WData = 64'hBB;
      @(negedge Clk);
      checks++;
      if (A_Done !== 1'b1) begin failures++; $display("FAIL field_done got=%b expected 1", A_Done); end
      A_Req = 1'b0;
      mem[1] = 64'hAA; prio = 1'b1;
      exp2 = mem[2];
      run_txn(1'b0, 1'b0, 3'd1, 64'h0, rd, gc, dc);
      checks++;
      if (rd !== 64'hAA) begin failures++; $display("FAIL field_reg1 got=%h expected=aa", rd); end
      run_txn(1'b0, 1'b0, 3'd2, 64'h0, rd, gc, dc);
      checks++;
      if (rd !== exp2) begin failures++; $display("FAIL field_reg2 got=%h expected=%h", rd, exp2); end
   endtask

   task automatic test_reset_in_access();
      bit seen = 1'b0; bit first_b = 1'b0; logic [63:0] ard = '1; bit b_done = 1'b0;
      do_reset();
      @(negedge Clk);
      set_req(1'b0, 1'b1, 3'd4, 64'h55);
      @(negedge Clk);
      checks++;
      if (A_Grant !== 1'b1) begin failures++; $display("FAIL abort_grant got=%b expected 1", A_Grant); end
      Reset = 1'b1; A_Req = 1'b0;
      @(negedge Clk);
      checks++;
      if (A_Done !== 1'b0 || Busy !== 1'b0) begin
         failures++; $display("FAIL abort_state done=%b busy=%b expected 0 0", A_Done, Busy);
      end
      Reset = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      exp_ard = '0; exp_brd = '0; prio = 1'b0;
      @(negedge Clk);
      set_req(1'b0, 1'b0, 3'd4, 64'h0);
      set_req(1'b1, 1'b0, 3'd4, 64'h0);
      for (int c = 1; c <= 20 && !b_done; c++) begin
         @(negedge Clk);
         if (A_Done) begin if (!seen) ard = A_RData; seen = 1'b1; A_Req = 1'b0; end
         if (B_Done) begin if (!seen) first_b = 1'b1; seen = 1'b1; b_done = 1'b1; B_Req = 1'b0; end
      end
      A_Req = 1'b0; B_Req = 1'b0; prio = 1'b0;
      checks++;
      if (first_b || ard !== 64'h0 || !b_done) begin
         failures++; $display("FAIL abort_after b_first=%b a_rdata=%h b_done=%b expected 0 0 1", first_b, ard, b_done);
      end
   endtask

   task automatic test_random();
      bit a_pend = 1'b0, b_pend = 1'b0, w, cw;
      logic [2:0] ca; logic [63:0] cd; logic [4:0] got, exp;
      do_reset();
      @(negedge Clk);
      for (int r = 0; r < 60; r++) begin
         if (!a_pend && $urandom_range(1, 0) == 1) begin
            a_pend = 1'b1; set_req(1'b0, 1'($urandom), 3'($urandom), {$urandom, $urandom});
         end
         if (!b_pend && $urandom_range(1, 0) == 1) begin
            b_pend = 1'b1; set_req(1'b1, 1'($urandom), 3'($urandom), {$urandom, $urandom});
         end
         if (!a_pend && !b_pend) begin
            b_pend = 1'b1; set_req(1'b1, 1'($urandom), 3'($urandom), {$urandom, $urandom});
         end
         w  = (a_pend && b_pend) ? prio : b_pend;
         cw = w ? B_Write : A_Write;
         ca = w ? B_Addr  : A_Addr;
         cd = w ? B_WData : A_WData;
         @(negedge Clk);
         got = {A_Grant, B_Grant, A_Done, B_Done, Busy};
         exp = {~w, w, 1'b0, 1'b0, 1'b1};
         checks++;
         if (got !== exp) begin failures++; $display("FAIL rnd_access r=%0d got=%b expected=%b", r, got, exp); end
         if (w) begin B_Addr = 3'($urandom); B_WData = {$urandom, $urandom}; end
         else   begin A_Addr = 3'($urandom); A_WData = {$urandom, $urandom}; end
         @(negedge Clk);
         if (cw) mem[ca] = cd;
         else if (w) exp_brd = mem[ca];
         else exp_ard = mem[ca];
         prio = ~w;
         got = {A_Grant, B_Grant, A_Done, B_Done, Busy};
         exp = {1'b0, 1'b0, ~w, w, 1'b1};
         checks++;
         if (got !== exp || A_RData !== exp_ard || B_RData !== exp_brd) begin
            failures++;
            $display("FAIL rnd_resp r=%0d got=%b expected=%b ard=%h/%h brd=%h/%h", r, got, exp,
                     A_RData, exp_ard, B_RData, exp_brd);
         end
         if (w) b_pend = 1'b0; else a_pend = 1'b0;
         if ($urandom_range(1, 0) == 1) begin
            set_req(w, 1'($urandom), 3'($urandom), {$urandom, $urandom});
            if (w) b_pend = 1'b1; else a_pend = 1'b1;
         end else begin
            if (w) B_Req = 1'b0; else A_Req = 1'b0;
         end
         @(negedge Clk);
         checks++;
         if ({A_Grant, B_Grant, A_Done, B_Done, Busy} !== 5'b0) begin
            failures++; $display("FAIL rnd_idle r=%0d got=%b expected 00000", r, {A_Grant, B_Grant, A_Done, B_Done, Busy});
         end
      end
      A_Req = 1'b0; B_Req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_cross_visibility();
      test_field_change();
      test_reset_in_access();
      test_random();
      repeat (2) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares a bank of 64-bit storage registers between two requesters, A and B.
- Each requester issues single read or write transactions over a req/grant/done handshake.
- Arbitration is round-robin; one transaction is in flight at a time, sequenced by a 3-state FSM.
- Sits between datapath clients and the register bank, replacing direct per-register En/Read driving.

Parameters:
- DATA_W, 64, width of each storage register and of the data buses.
- ADDR_W, 3, register index width.
- NUM_REGS, 8, number of implemented registers; must be <= 2**ADDR_W.

Ports:
- Clk  input  1  system clock, all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- A_Req  input  1  requester A transaction request, level.
- A_Write  input  1  1 = write, 0 = read; sampled with A_Req.
- A_Addr  input  ADDR_W  register index.
- A_WData  input  DATA_W  write data.
- A_Grant  output  1  high during the ACCESS cycle serving A.
- A_Done  output  1  one-cycle pulse when A's transaction completes.
- A_RData  output  DATA_W  read data; valid while A_Done=1, held until A's next read completes.
- B_Req, B_Write, B_Addr, B_WData, B_Grant, B_Done, B_RData: same as A, for requester B.
- Busy  output  1  high when the FSM is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM enters IDLE.
  - All storage registers are cleared to 0.
  - All Grant, Done and Busy outputs = 0; A_RData = B_RData = 0.
  - Priority pointer points to A.
- Reset asserted mid-transaction aborts it: no Done pulse, and no write is committed if Reset is high in the ACCESS cycle.
- IDLE:
  - If no Req is high, stay in IDLE.
  - If exactly one Req is high, select that requester.
  - If both are high, select the one the priority pointer names.
  - On selection, latch owner, Write, Addr and WData into internal command registers; next state is ACCESS.
- ACCESS, one cycle:
  - Grant of the owner = 1; Busy = 1.
  - Write: storage[Addr] <= WData at the end of the cycle.
  - Read: storage[Addr] is captured into the owner's RData register at the end of the cycle.
  - The other requester's RData is unchanged.
  - Priority pointer is set to the non-owner.
  - Next state is RESP.
- RESP, one cycle:
  - Owner's Done = 1; Busy = 1; next state is IDLE.
- Latency: Req high at edge N (FSM in IDLE) gives Grant in cycle N+1 and Done in cycle N+2. Minimum spacing between back-to-back transactions is 3 cycles.
- Req is a level signal:
  - A requester keeps Req high until it sees Done.
  - Req still high in the IDLE cycle after Done is treated as a new request.
  - Dropping Req after capture does not cancel the transaction; Done still pulses.
- Command fields are sampled only on the IDLE->ACCESS transition; later changes to Addr, WData or Write are ignored.
- Read-after-write to the same address by the other requester returns the new data, because the write commits in ACCESS, before the next transaction's ACCESS.
- Out-of-range address (Addr >= NUM_REGS): a write is discarded; a read returns 0. The handshake proceeds normally.
- Fairness: with both Req held continuously, grants alternate A, B, A, B...; neither requester waits more than one foreign transaction.
- Grant and Done are never high for both requesters in the same cycle. At most one of Grant/Done is high per cycle overall.

Test Plan:
- Reset then idle: hold Reset 2 cycles, then release; all Req = 0 -> Busy, Grant and Done stay 0; a read of any address by A returns 0.
- A writes reg 3 = 64'hDEAD_BEEF_0123_4567 -> A_Grant in cycle N+1, A_Done in N+2. A then reads reg 3 -> A_RData = 64'hDEAD_BEEF_0123_4567 with A_Done; B_RData unchanged.
- Contention after reset: A and B both request in the same cycle, B writing reg 5 = 64'h1 -> A served first, then B. With both held for 6 transactions, the order is A, B, A, B, A, B; Done pulses are 3 cycles apart.
- Cross visibility: A writes reg 7 = 64'hFFFF_0000_FFFF_0000 while B requests a read of reg 7 -> B_RData = 64'hFFFF_0000_FFFF_0000.
- Field change after capture: A requests a write to reg 1 = 64'hAA, then changes A_Addr to 2 and A_WData to 64'hBB during ACCESS -> reg 1 = 64'hAA and reg 2 is unchanged.
- Reset during ACCESS of an A write to reg 4 = 64'h55 -> no A_Done, reg 4 = 0, FSM in IDLE, priority pointer points to A.
